// File: rtl/be_clock_pkg.sv
// Shared constants and helpers for the computer clock generator.
// Divider terminal counts are computed at elaboration time from the oscillator frequency.
// No flow control: pure definitions.
package be_clock_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEF = 50_000_000;
    localparam int unsigned CNT_W           = $clog2(CLK_FREQ_HZ_DEF);

    typedef enum logic {
        MODE_CONT   = 1'b0,
        MODE_MANUAL = 1'b1
    } clk_mode_e;

    // Half-period length in oscillator cycles for an output of 2^div Hz.
    function automatic int unsigned half_count(input int unsigned freq, input logic [2:0] div);
        return freq / (32'd2 << div);
    endfunction

    // Terminal value the divider counter compares against (never below zero).
    function automatic int unsigned half_limit(input int unsigned freq, input logic [2:0] div);
        int unsigned h;
        h = half_count(freq, div);
        return (h == 0) ? 0 : h - 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned freq);
        return ($clog2(freq) > CNT_W) ? $clog2(freq) : CNT_W;
    endfunction

endpackage

// File: rtl/be_clock_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for a bouncy push button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before the level changes.
// No backpressure: output is a level, updated every cycle.
module be_clock_debounce
    import be_clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic btn,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          btn_s1;
    logic          btn_s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (btn_s2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= btn_s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/be_clock_gen.sv
// Computer clock source: divided continuous clock, debounced manual step, active-low halt.
// Latency: HLT/CLK_SELECT to CLK 3 cycles; CLK_STEP to CLK 3 + DEBOUNCE_CYCLES cycles.
// No backpressure: CLK/NOT_CLK are free-running registered outputs.
module be_clock_gen
    import be_clock_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       CLK_SELECT,
    input  logic       CLK_STEP,
    input  logic       HLT,
    input  logic [2:0] DIV_CLK,
    output logic       CLK,
    output logic       NOT_CLK
);

    localparam int unsigned CW = cnt_width(CLK_FREQ_HZ);

    logic          sel_s1;
    logic          sel_s2;
    logic          hlt_s1;
    logic          hlt_s2;
    logic [2:0]    div_s1;
    logic [2:0]    div_s2;
    logic          step_lvl;
    clk_mode_e     mode;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] half_lim;
    logic          cont_clk;
    logic          cont_nxt;
    logic          clk_nxt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sel_s1 <= 1'b0;
            sel_s2 <= 1'b0;
            hlt_s1 <= 1'b0;
            hlt_s2 <= 1'b0;
            div_s1 <= '0;
            div_s2 <= '0;
        end else begin
            sel_s1 <= CLK_SELECT;
            sel_s2 <= sel_s1;
            hlt_s1 <= HLT;
            hlt_s2 <= hlt_s1;
            div_s1 <= DIV_CLK;
            div_s2 <= div_s1;
        end
    end

    be_clock_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .btn   (CLK_STEP),
        .level (step_lvl)
    );

    assign mode = clk_mode_e'(sel_s2);

    // Eight constant terminal counts; the selected rate just picks one.
    always_comb begin
        half_lim = '0;
        for (int k = 0; k < 8; k++) begin
            if (div_s2 == 3'(k)) begin
                half_lim = CW'(half_limit(CLK_FREQ_HZ, 3'(k)));
            end
        end
    end

    // Divider parks at zero with a low phase whenever it is not the active source,
    // so resuming always starts with a full low half-period.
    always_comb begin
        cnt_nxt  = cnt;
        cont_nxt = cont_clk;
        clk_nxt  = CLK;
        if (!hlt_s2 || mode == MODE_MANUAL) begin
            cnt_nxt  = '0;
            cont_nxt = 1'b0;
        end else if (cnt >= half_lim) begin
            cnt_nxt  = '0;
            cont_nxt = ~cont_clk;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end

        if (!hlt_s2) begin
            clk_nxt = 1'b0;
        end else if (mode == MODE_MANUAL) begin
            clk_nxt = step_lvl;
        end else begin
            clk_nxt = cont_clk;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt      <= '0;
            cont_clk <= 1'b0;
            CLK      <= 1'b0;
            NOT_CLK  <= 1'b1;
        end else begin
            cnt      <= cnt_nxt;
            cont_clk <= cont_nxt;
            CLK      <= clk_nxt;
            NOT_CLK  <= ~clk_nxt;
        end
    end

endmodule

// File: tb/tb_be_clock_gen.sv
// Self-checking bench for be_clock_gen with a 1 kHz oscillator and 4-cycle debounce.
// Edge times are compared against periods and latencies computed from the clock rules.
module tb_be_clock_gen;

    localparam int unsigned FREQ = 1000;
    localparam int unsigned DEB  = 4;

    logic       CLK_tb = 1'b0;
    logic       rst;
    logic       clk_select;
    logic       clk_step;
    logic       hlt;
    logic [2:0] div_clk;
    logic       clk;
    logic       not_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rises[$];
    int falls[$];
    logic clk_prev;
    logic exp_nc;
    bit   mon_on = 1'b0;

    always #10 CLK_tb = ~CLK_tb;

    be_clock_gen #(
        .CLK_FREQ_HZ     (FREQ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .iCLK       (CLK_tb),
        .iRST       (rst),
        .CLK_SELECT (clk_select),
        .CLK_STEP   (clk_step),
        .HLT        (hlt),
        .DIV_CLK    (div_clk),
        .CLK        (clk),
        .NOT_CLK    (not_clk)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int half_of(input int d);
        return FREQ / (2 << d);
    endfunction

    always @(posedge CLK_tb) cyc++;

    // Records the edge index of every CLK transition and checks the complement each cycle.
    always @(negedge CLK_tb) begin
        if (mon_on) begin
            exp_nc = ~clk;
            chk_eq("not_clk_complement", not_clk, exp_nc);
            if (clk_prev === 1'b0 && clk === 1'b1) rises.push_back(cyc);
            if (clk_prev === 1'b1 && clk === 1'b0) falls.push_back(cyc);
            clk_prev = clk;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK_tb);
            #1;
        end
    endtask

    task automatic wait_edge(input bit rise, input string tag, input int budget, output int at);
        int n0;
        bit seen;
        n0   = rise ? rises.size() : falls.size();
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (rise ? (rises.size() > n0) : (falls.size() > n0)) begin
                seen = 1'b1;
                at   = rise ? rises[n0] : falls[n0];
            end
        end
        chk_eq({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int c0, c1, r, r2, r3, f, off, w, n0, d, nb;
        logic hi;

        rst = 1'b1; clk_select = 1'b0; clk_step = 1'b0; hlt = 1'b1; div_clk = 3'd0;
        @(posedge CLK_tb);
        #1;
        clk_prev = clk;
        mon_on   = 1'b1;
        tick(3);
        chk_eq("reset_clk", clk, 0);
        chk_eq("reset_not_clk", not_clk, 1);

        // Continuous 1 Hz after reset release
        rst = 1'b0;
        c0  = cyc;
        wait_edge(1, "s1_rise", 700, r);
        chk_eq("s1_first_rise", r - c0, 3 + half_of(0));
        wait_edge(0, "s1_fall", 700, f);
        chk_eq("s1_high", f - r, half_of(0));
        wait_edge(1, "s1_rise2", 700, r2);
        chk_eq("s1_low", r2 - f, half_of(0));

        // Every rate, changed just after a rising edge
        for (int k = 0; k < 8; k++) begin
            div_clk = 3'(k);
            wait_edge(1, "s2_settle", 1100, r);
            wait_edge(0, "s2_fall", 1100, f);
            wait_edge(1, "s2_rise", 1100, r2);
            chk_eq($sformatf("s2_high_div%0d", k), f - r, half_of(k));
            chk_eq($sformatf("s2_period_div%0d", k), r2 - r, 2 * half_of(k));
        end

        // Slow-to-fast switch cuts the current high phase short
        div_clk = 3'd4;
        wait_edge(1, "fast_settle", 100, r);
        wait_edge(1, "fast_base", 100, r);
        div_clk = 3'd7;
        wait_edge(0, "fast_fall", 100, f);
        chk_eq("fast_switch_high", f - r, 4);
        wait_edge(1, "fast_r1", 100, r2);
        wait_edge(1, "fast_r2", 100, r3);
        chk_eq("fast_period", r3 - r2, 2 * half_of(7));

        // Halt while high, then release
        wait_edge(1, "halt_base", 100, r);
        off = $urandom_range(0, 2);
        tick(off);
        hlt = 1'b0;
        c0  = cyc;
        n0  = rises.size();
        tick(3);
        chk_eq("halt_clk_low", clk, 0);
        hi = 1'b0;
        for (int i = 0; i < 97; i++) begin
            tick(1);
            hi = hi | clk;
        end
        chk_eq("halt_hold_low", hi, 0);
        chk_eq("halt_no_rise", rises.size() - n0, 0);
        hlt = 1'b1;
        c0  = cyc;
        wait_edge(1, "halt_rel_rise", 50, r);
        chk_eq("halt_release_rise", r - c0, 3 + half_of(7));
        wait_edge(1, "halt_r2", 50, r2);
        wait_edge(1, "halt_r3", 50, r3);
        chk_eq("halt_period_a", r2 - r, 2 * half_of(7));
        chk_eq("halt_period_b", r3 - r2, 2 * half_of(7));

        // Switch to manual while CLK is high
        div_clk = 3'd5;
        wait_edge(1, "man_settle", 100, r);
        wait_edge(1, "man_base", 100, r);
        clk_select = 1'b1;
        wait_edge(0, "man_sw_fall", 20, f);
        chk_eq("man_switch_latency", f - r, 3);
        n0 = rises.size();
        tick(10);
        chk_eq("man_idle_low", clk, 0);

        for (int p = 0; p < 3; p++) begin
            w = $urandom_range(20, 60);
            clk_step = 1'b1;
            c0 = cyc;
            wait_edge(1, "step_rise", 20, r);
            chk_eq($sformatf("step_rise_lat%0d", p), r - c0, 3 + DEB);
            tick(w - (cyc - c0));
            clk_step = 1'b0;
            c1 = cyc;
            wait_edge(0, "step_fall", 20, f);
            chk_eq($sformatf("step_fall_lat%0d", p), f - c1, 3 + DEB);
            chk_eq($sformatf("step_high_width%0d", p), f - r, w);
            tick(50 - (cyc - c1));
        end
        chk_eq("step_pulse_count", rises.size() - n0, 3);

        // Bouncing button never reaches the debounce count
        n0 = rises.size();
        nb = 2 * $urandom_range(3, 8);
        for (int i = 0; i < nb; i++) begin
            clk_step = ~clk_step;
            tick(2);
        end
        chk_eq("bounce_no_rise", rises.size() - n0, 0);
        chk_eq("bounce_clk_low", clk, 0);
        clk_step = 1'b1;
        c0 = cyc;
        wait_edge(1, "bounce_settle_rise", 20, r);
        chk_eq("bounce_settle_lat", r - c0, 3 + DEB);
        tick(10);
        clk_step = 1'b0;
        wait_edge(0, "bounce_release", 20, f);

        // Back to continuous at a random rate
        d = $urandom_range(5, 7);
        div_clk = 3'(d);
        tick(5);
        clk_select = 1'b0;
        c0 = cyc;
        wait_edge(1, "cont_resume", 100, r);
        chk_eq("cont_resume_rise", r - c0, 3 + half_of(d));

        // Reset in the middle of a high phase
        wait_edge(1, "rst_base", 100, r);
        off = $urandom_range(0, half_of(d) - 2);
        tick(off);
        chk_eq("rst_pre_high", clk, 1);
        rst = 1'b1;
        tick(1);
        chk_eq("rst_mid_clk", clk, 0);
        chk_eq("rst_mid_not_clk", not_clk, 1);
        tick(2);
        rst = 1'b0;
        c0  = cyc;
        wait_edge(1, "rst_rel_rise", 100, r);
        chk_eq("rst_release_rise", r - c0, 3 + half_of(d));
        wait_edge(1, "rst_r2", 100, r2);
        chk_eq("rst_period", r2 - r, 2 * half_of(d));

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
